// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared definitions for the Tomasulo common-data-bus arbiter.
//   - default widths (requesters, data, tag, register index)
//   - CDB opcode constants
//   - packed broadcast struct {valid, tag, data, dest, wb}
//   - ptr_w(): bit width of a pointer over n entries (minimum 1)
package cdb_arbiter_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned DW_DEF   = 16;
  localparam int unsigned TAGW_DEF = 3;
  localparam int unsigned RW_DEF   = 3;

  typedef enum logic [3:0] {
    OP_ADD_D = 4'b0000,
    OP_SUB_D = 4'b0001,
    OP_L_D   = 4'b0010,
    OP_S_D   = 4'b0011
  } cdb_op_e;

  typedef struct packed {
    logic                valid;
    logic [TAGW_DEF-1:0] tag;
    logic [DW_DEF-1:0]   data;
    logic [RW_DEF-1:0]   dest;
    logic                wb;
  } cdb_bcast_t;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Stores complete on the CDB but never write the register file.
  function automatic logic op_writes_rf(input cdb_op_e op);
    return op != OP_S_D;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: request/broadcast bus between the functional units and the
// CDB arbiter.
//   master : requesters / consumers side (drives req*, cdb_stall)
//   slave  : arbiter side (drives grant, cdb_*, rf_*)
// Requester i occupies slice i of req_tag/req_data/req_dest.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned TAGW = TAGW_DEF,
  parameter int unsigned RW   = RW_DEF
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_wb;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ*RW-1:0]   req_dest;
  logic                 cdb_stall;
  logic [NREQ-1:0]      grant;
  logic                 cdb_valid;
  logic [TAGW-1:0]      cdb_tag;
  logic [DW-1:0]        cdb_data;
  logic [RW-1:0]        cdb_dest;
  logic                 rf_we;
  logic [RW-1:0]        rf_addr;
  logic [DW-1:0]        rf_data;

  modport master (
    output req, req_wb, req_tag, req_data, req_dest, cdb_stall,
    input  grant, cdb_valid, cdb_tag, cdb_data, cdb_dest, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  req, req_wb, req_tag, req_data, req_dest, cdb_stall,
    output grant, cdb_valid, cdb_tag, cdb_data, cdb_dest, rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot selector.
//   i_req    : request vector
//   i_prio   : index with highest priority; search order prio, prio+1, ... mod NREQ
//   o_grant  : one-hot winner (zero when no request)
//   o_winner : winner index (zero when no request)
//   o_any    : at least one request present
module rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_prio,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_winner,
  output logic            o_any
);

  int unsigned w_dist;
  int unsigned w_best;
  int unsigned w_sel;

  // Winner is the requester with the smallest rotated distance from i_prio;
  // this avoids variable-index modulo arithmetic on the request vector.
  always_comb begin
    w_dist = 0;
    w_best = NREQ;
    w_sel  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - 32'(i_prio)) % NREQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = i;
      end
    end
  end

  assign o_any    = |i_req;
  assign o_winner = PW'(w_sel);

  always_comb begin
    o_grant = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (o_any && (w_sel == i)) o_grant[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and broadcast register for the Tomasulo
// common data bus.
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : cdb_arbiter_if.slave (requests in; grant, CDB broadcast and
//            register-file write out)
// Optional build macro CDB_PERF_EN adds:
//   o_perf_bcast    : saturating count of broadcasts
//   o_perf_conflict : saturating count of non-stalled cycles with >=2 requests
// Grant is combinational in the request cycle; the broadcast and register-file
// write appear one cycle later for exactly one cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned TAGW = TAGW_DEF,
  parameter int unsigned RW   = RW_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  cdb_arbiter_if.slave   bus
`ifdef CDB_PERF_EN
  ,
  output logic [15:0]    o_perf_bcast,
  output logic [15:0]    o_perf_conflict
`endif
);

  localparam int unsigned PW = ptr_w(NREQ);

  logic [PW-1:0]   r_prio;
  logic            r_valid;
  logic [TAGW-1:0] r_tag;
  logic [DW-1:0]   r_data;
  logic [RW-1:0]   r_dest;
  logic            r_wb;

  logic [NREQ-1:0] w_pick_grant;
  logic [PW-1:0]   w_winner;
  logic            w_any;
  logic            w_fire;
  logic [TAGW-1:0] w_tag;
  logic [DW-1:0]   w_data;
  logic [RW-1:0]   w_dest;
  logic            w_wb;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (bus.req),
    .i_prio   (r_prio),
    .o_grant  (w_pick_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_fire    = w_any & ~bus.cdb_stall;
  assign bus.grant = w_fire ? w_pick_grant : '0;

  // One-hot payload mux driven by the selector's grant.
  always_comb begin
    w_tag  = '0;
    w_data = '0;
    w_dest = '0;
    w_wb   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_pick_grant[i]) begin
        w_tag  = bus.req_tag[i*TAGW +: TAGW];
        w_data = bus.req_data[i*DW +: DW];
        w_dest = bus.req_dest[i*RW +: RW];
        w_wb   = bus.req_wb[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio  <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_dest  <= '0;
      r_wb    <= 1'b0;
    end else begin
      r_valid <= w_fire;
      if (w_fire) begin
        r_tag  <= w_tag;
        r_data <= w_data;
        r_dest <= w_dest;
        r_wb   <= w_wb;
        r_prio <= (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + PW'(1);
      end
    end
  end

  assign bus.cdb_valid = r_valid;
  assign bus.cdb_tag   = r_tag;
  assign bus.cdb_data  = r_data;
  assign bus.cdb_dest  = r_dest;
  // Register 0 is hard-wired, so a broadcast to it never writes.
  assign bus.rf_we     = r_valid & r_wb & (r_dest != '0);
  assign bus.rf_addr   = r_dest;
  assign bus.rf_data   = r_data;

`ifdef CDB_PERF_EN
  logic [15:0] r_perf_bcast;
  logic [15:0] r_perf_conflict;
  logic        w_conflict;

  assign w_conflict = ~bus.cdb_stall & ($countones(bus.req) > 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_bcast    <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (w_fire && (r_perf_bcast != '1))        r_perf_bcast    <= r_perf_bcast + 16'd1;
      if (w_conflict && (r_perf_conflict != '1)) r_perf_conflict <= r_perf_conflict + 16'd1;
    end
  end

  assign o_perf_bcast    = r_perf_bcast;
  assign o_perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int TAGW = 3;
  localparam int RW   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NREQ(NREQ), .DW(DW), .TAGW(TAGW), .RW(RW)) bus ();

`ifdef CDB_PERF_EN
  logic [15:0] perf_bcast;
  logic [15:0] perf_conflict;
`endif

  cdb_arbiter #(.NREQ(NREQ), .DW(DW), .TAGW(TAGW), .RW(RW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef CDB_PERF_EN
    ,
    .o_perf_bcast    (perf_bcast),
    .o_perf_conflict (perf_conflict)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side stimulus state
  logic [NREQ-1:0] req_v;
  logic            stall_v;
  logic [TAGW-1:0] tag_a  [NREQ];
  logic [DW-1:0]   data_a [NREQ];
  logic [RW-1:0]   dest_a [NREQ];
  logic            wb_a   [NREQ];

  // Reference model: priority pointer plus last broadcast
  int         m_prio;
  cdb_bcast_t m_b;
  int         m_bcast;
  int         m_conf;

  function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] r, input logic st, input int p);
    logic [NREQ-1:0] g;
    g = '0;
    if (!st) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g == '0 && r[(p + k) % NREQ]) g[(p + k) % NREQ] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic [TAGW-1:0] t, input logic [DW-1:0] d,
                         input logic [RW-1:0] r, input logic w);
    req_v[i]  = 1'b1;
    tag_a[i]  = t;
    data_a[i] = d;
    dest_a[i] = r;
    wb_a[i]   = w;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]                     = req_v[i];
      bus.req_wb[i]                  = wb_a[i];
      bus.req_tag[i*TAGW +: TAGW]    = tag_a[i];
      bus.req_data[i*DW +: DW]       = data_a[i];
      bus.req_dest[i*RW +: RW]       = dest_a[i];
    end
    bus.cdb_stall = stall_v;
  endtask

  // Advance one clock, applying the arbitration rules to the model, and
  // return at the following falling edge.
  task automatic tick();
    logic [NREQ-1:0] g;
    g = exp_grant(req_v, stall_v, m_prio);
    @(posedge clk);
    if (rst) begin
      m_prio  = 0;
      m_b     = '0;
      m_bcast = 0;
      m_conf  = 0;
    end else begin
      if (!stall_v && $countones(req_v) >= 2 && m_conf < 65535) m_conf++;
      m_b.valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          m_b.valid = 1'b1;
          m_b.tag   = tag_a[i];
          m_b.data  = data_a[i];
          m_b.dest  = dest_a[i];
          m_b.wb    = wb_a[i];
          m_prio    = (i + 1) % NREQ;
          if (m_bcast < 65535) m_bcast++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_v = '0; stall_v = 1'b0; drive();
    tick(); tick();
    rst = 1'b0; drive();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (bus.grant !== 4'b0000) begin
      n_fail++; $display("FAIL reset_grant: got %b expected 0000", bus.grant);
    end
    n_tests++;
    if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_dest} !== '0) begin
      n_fail++; $display("FAIL reset_cdb: valid=%b tag=%0d data=%h dest=%0d expected all 0",
                         bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_dest);
    end
    n_tests++;
    if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== '0) begin
      n_fail++; $display("FAIL reset_rf: we=%b addr=%0d data=%h expected all 0",
                         bus.rf_we, bus.rf_addr, bus.rf_data);
    end
`ifdef CDB_PERF_EN
    n_tests++;
    if (perf_bcast !== 16'd0 || perf_conflict !== 16'd0) begin
      n_fail++; $display("FAIL reset_perf: bcast=%0d conflict=%0d expected 0 0", perf_bcast, perf_conflict);
    end
`endif
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 3'd5, 16'h1234, 3'd3, 1'b1); drive();
    #1;
    n_tests++;
    if (bus.grant !== 4'b0100) begin
      n_fail++; $display("FAIL single_grant: got %b expected 0100", bus.grant);
    end
    tick();
    req_v = '0; drive(); #1;
    n_tests++;
    if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data} !== {1'b1, 3'd5, 16'h1234}) begin
      n_fail++; $display("FAIL single_cdb: valid=%b tag=%0d data=%h expected 1 5 1234",
                         bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
    n_tests++;
    if ({bus.rf_we, bus.rf_addr, bus.rf_data} !== {1'b1, 3'd3, 16'h1234}) begin
      n_fail++; $display("FAIL single_rf: we=%b addr=%0d data=%h expected 1 3 1234",
                         bus.rf_we, bus.rf_addr, bus.rf_data);
    end
    tick(); #1;
    n_tests++;
    if (bus.cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse: cdb_valid=%b expected 0", bus.cdb_valid);
    end
    req_v = '1; drive(); #1;
    n_tests++;
    if (bus.grant !== 4'b1000) begin
      n_fail++; $display("FAIL single_prio3: got %b expected 1000", bus.grant);
    end
    tick();
    req_v = '0; drive(); tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, TAGW'(i + 1), DW'($urandom), RW'(i + 1), 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(); #1;
      n_tests++;
      if (bus.grant !== 4'(1 << (k % NREQ))) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.grant, 4'(1 << (k % NREQ)));
      end
      if (k > 0) begin
        n_tests++;
        if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== TAGW'(((k - 1) % NREQ) + 1)) begin
          n_fail++; $display("FAIL rr_cdb[%0d]: valid=%b tag=%0d expected 1 %0d",
                             k, bus.cdb_valid, bus.cdb_tag, ((k - 1) % NREQ) + 1);
        end
      end
      tick();
    end
    req_v = '0; drive(); #1;
    n_tests++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 3'd4) begin
      n_fail++; $display("FAIL rr_last: valid=%b tag=%0d expected 1 4", bus.cdb_valid, bus.cdb_tag);
    end
    tick();
  endtask

  task automatic test_no_write();
    set_req(3, 3'd6, 16'hBEEF, 3'd4, op_writes_rf(OP_S_D)); drive(); tick();
    req_v = '0; drive(); #1;
    n_tests++;
    if ({bus.cdb_valid, bus.cdb_dest, bus.rf_we} !== {1'b1, 3'd4, 1'b0}) begin
      n_fail++; $display("FAIL store_nowrite: valid=%b dest=%0d rf_we=%b expected 1 4 0",
                         bus.cdb_valid, bus.cdb_dest, bus.rf_we);
    end
    set_req(1, 3'd2, 16'h0F0F, 3'd0, op_writes_rf(OP_ADD_D)); drive(); tick();
    req_v = '0; drive(); #1;
    n_tests++;
    if ({bus.cdb_valid, bus.cdb_data, bus.rf_we} !== {1'b1, 16'h0F0F, 1'b0}) begin
      n_fail++; $display("FAIL r0_nowrite: valid=%b data=%h rf_we=%b expected 1 0f0f 0",
                         bus.cdb_valid, bus.cdb_data, bus.rf_we);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, 3'd1, 16'h1111, 3'd1, 1'b1);
    set_req(1, 3'd2, 16'h2222, 3'd2, 1'b1);
    stall_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(); #1;
      n_tests++;
      if (bus.grant !== 4'b0000) begin
        n_fail++; $display("FAIL stall_grant[%0d]: got %b expected 0000", k, bus.grant);
      end
      tick(); #1;
      n_tests++;
      if (bus.cdb_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_valid[%0d]: cdb_valid=%b expected 0", k, bus.cdb_valid);
      end
    end
    stall_v = 1'b0; drive(); #1;
    n_tests++;
    if (bus.grant !== 4'b0001) begin
      n_fail++; $display("FAIL stall_release: got %b expected 0001", bus.grant);
    end
    tick();
    req_v = '0; drive(); tick();
  endtask

  task automatic test_reset_in_grant();
    do_reset();
    set_req(1, 3'd3, 16'hAAAA, 3'd5, 1'b1); drive(); tick();
    req_v = '0;
    set_req(2, 3'd7, 16'h5555, 3'd6, 1'b1);
    rst = 1'b1; drive(); #1;
    n_tests++;
    if (bus.grant !== 4'b0100) begin
      n_fail++; $display("FAIL rstgrant_grant: got %b expected 0100", bus.grant);
    end
    tick();
    rst = 1'b0; req_v = '0; drive(); #1;
    n_tests++;
    if (bus.cdb_valid !== 1'b0 || bus.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL rstgrant_valid: cdb_valid=%b rf_we=%b expected 0 0", bus.cdb_valid, bus.rf_we);
    end
`ifdef CDB_PERF_EN
    n_tests++;
    if (perf_bcast !== 16'd0) begin
      n_fail++; $display("FAIL rstgrant_perf: perf_bcast=%0d expected 0", perf_bcast);
    end
`endif
    req_v = '1; drive(); #1;
    n_tests++;
    if (bus.grant !== 4'b0001) begin
      n_fail++; $display("FAIL rstgrant_prio: got %b expected 0001", bus.grant);
    end
    tick();
    req_v = '0; drive(); tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] eg;
    int              wait_c [NREQ];
    do_reset();
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    for (int c = 0; c < 400; c++) begin
      stall_v = ($urandom_range(3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v[i] && $urandom_range(2) == 0)
          set_req(i, TAGW'($urandom), DW'($urandom), RW'($urandom),
                  op_writes_rf(cdb_op_e'($urandom_range(3))));
        else if (req_v[i] && $urandom_range(19) == 0)
          req_v[i] = 1'b0;
      end
      drive(); #1;
      eg = exp_grant(req_v, stall_v, m_prio);
      n_tests++;
      if (bus.grant !== eg) begin
        n_fail++; $display("FAIL rand_grant[%0d]: got %b expected %b (req=%b stall=%b)",
                           c, bus.grant, eg, req_v, stall_v);
      end
      n_tests++;
      if ({bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_dest} !== {m_b.valid, m_b.tag, m_b.data, m_b.dest}) begin
        n_fail++; $display("FAIL rand_cdb[%0d]: got v=%b t=%0d d=%h r=%0d expected v=%b t=%0d d=%h r=%0d",
                           c, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_dest,
                           m_b.valid, m_b.tag, m_b.data, m_b.dest);
      end
      n_tests++;
      if ({bus.rf_we, bus.rf_addr, bus.rf_data} !==
          {m_b.valid & m_b.wb & (m_b.dest != 0), m_b.dest, m_b.data}) begin
        n_fail++; $display("FAIL rand_rf[%0d]: got we=%b a=%0d d=%h expected we=%b a=%0d d=%h",
                           c, bus.rf_we, bus.rf_addr, bus.rf_data,
                           m_b.valid & m_b.wb & (m_b.dest != 0), m_b.dest, m_b.data);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v[i] || eg[i]) wait_c[i] = 0;
        else if (!stall_v) begin
          wait_c[i]++;
          n_tests++;
          if (wait_c[i] >= NREQ) begin
            n_fail++; $display("FAIL rand_starve[%0d]: requester %0d waited %0d cycles, bound %0d",
                               c, i, wait_c[i], NREQ - 1);
          end
        end
      end
      tick();
      for (int i = 0; i < NREQ; i++) if (eg[i]) req_v[i] = 1'b0;
    end
`ifdef CDB_PERF_EN
    n_tests++;
    if (perf_bcast !== 16'(m_bcast) || perf_conflict !== 16'(m_conf)) begin
      n_fail++; $display("FAIL rand_perf: bcast=%0d conflict=%0d expected %0d %0d",
                         perf_bcast, perf_conflict, m_bcast, m_conf);
    end
`endif
    req_v = '0; stall_v = 1'b0; drive(); tick();
  endtask

  initial begin
    rst = 1'b1; req_v = '0; stall_v = 1'b0;
    m_prio = 0; m_b = '0; m_bcast = 0; m_conf = 0;
    for (int i = 0; i < NREQ; i++) begin
      tag_a[i] = '0; data_a[i] = '0; dest_a[i] = '0; wb_a[i] = 1'b0;
    end
    drive();
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_no_write();
    test_stall();
    test_reset_in_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter and broadcast register for the Tomasulo common data bus. Reservation stations and the load/store unit raise completion requests. One winner per cycle is granted. Its tag, result and destination are registered and broadcast on the CDB. A register-file write is issued for writeback-class results. The block sits between the functional-unit outputs and the FP register file / reservation-station tag snoop.

## Interface
- NREQ, 4: number of requesters (adder RS, multiplier RS, load, store)
- DW, 16: data width
- TAGW, 3: reservation-station tag width
- RW, 3: register index width (R1..R7; index 0 never written)
- clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- req  in  NREQ  completion request per requester, held until granted
- req_wb  in  NREQ  1 = result writes register file (ADD.D/SUB.D/L.D), 0 = no write (S.D)
- req_tag  in  NREQ*TAGW  producing tag, requester i at slice i
- req_data  in  NREQ*DW  result value
- req_dest  in  NREQ*RW  destination register
- cdb_stall  in  1  consumer cannot accept a broadcast this cycle
- grant  out  NREQ  one-hot, combinational, valid same cycle as req
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAGW
- cdb_data  out  DW
- cdb_dest  out  RW
- rf_we  out  1  register-file write enable
- rf_addr  out  RW
- rf_data  out  DW

## Operation
- Pointer `prio` (log2 NREQ bits) names the highest-priority requester. The search order is prio, prio+1, … mod NREQ.
- Each cycle with cdb_stall=0 and any req high:
  - Exactly one grant bit is asserted for the first requesting index in search order.
  - At the clock edge the winner's tag/data/dest are latched into the broadcast register and cdb_valid=1.
  - prio is set to winner+1 mod NREQ.
- No request, or cdb_stall=1:
  - grant=0 and cdb_valid=0 next cycle.
  - prio is unchanged.
  - cdb_tag/data/dest hold their last value.
- rf_we = cdb_valid & latched req_wb & (cdb_dest≠0). rf_addr=cdb_dest, rf_data=cdb_data.
- Requester protocol: payload is held stable while req=1. The requester sees grant=1 and drops req (or presents the next result) in the following cycle. A req deasserted without a grant is legal and is ignored.
- Arbitration is purely a function of req and prio. req_wb does not affect priority.

## Timing
- Reset: prio=0, grant=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_dest=0, rf_we=0, rf_addr=0, rf_data=0.
- Latency: req/grant in cycle t, broadcast and rf write visible in cycle t+1, one cycle wide.
- Throughput: one broadcast per cycle. Back-to-back broadcasts from different requesters are allowed.
- Starvation bound: a held request is granted within NREQ non-stalled cycles.
- Reset takes priority over everything. A Reset asserted in the same cycle as a grant discards that grant's broadcast. The requester has seen grant and must itself be reset.
- cdb_stall high for k cycles: no grants, and the pending requests keep their order relative to prio.
- Wrap-around: winner NREQ-1 sets prio=0.

## Configuration
- `CDB_PERF_EN` defined: adds output ports perf_bcast (16 bits) and perf_conflict (16 bits).
  - perf_bcast counts broadcasts.
  - perf_conflict counts non-stalled cycles with ≥2 requests.
  - Both counters saturate at 16'hFFFF and are cleared by Reset.
- Not defined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package:
  - CDB opcode constants (ADD.D=4'b0000, SUB.D=4'b0001, L.D=4'b0010, S.D=4'b0011).
  - Default widths DW/TAGW/RW.
  - A packed CDB broadcast struct {valid, tag, data, dest, wb}.
- Sub-module `rr_pick` holds the combinational round-robin one-hot selector (req, prio → grant, winner index). The top level holds the pointer, broadcast register and perf counters.

## Test plan
- Reset, then req=4'b0000 → grant=0, cdb_valid=0, all outputs 0.
- Single req[2] with tag=5, data=16'h1234, dest=3, wb=1 → grant=4'b0100 same cycle. Next cycle cdb_valid=1, cdb_tag=5, rf_we=1, rf_addr=3, rf_data=16'h1234. prio becomes 3.
- req=4'b1111 held for 8 cycles from prio=0 → grants 0,1,2,3,0,1,2,3, one per cycle, cdb_valid continuously 1.
- Store on req[3] (wb=0, dest=4) → cdb_valid=1, rf_we=0. Write to dest=0 with wb=1 → rf_we=0.
- req=4'b0011 with cdb_stall=1 for 3 cycles → no grants, prio unchanged. Stall drops → grant=4'b0001 (prio=0).
- Reset asserted in a grant cycle → next cycle cdb_valid=0, prio=0. With CDB_PERF_EN, perf_bcast=0.
